// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - sequential load/store unit between execute stage and byte-enabled data BRAM
// Splits word-crossing accesses into two beats (or faults them) and extends load data.
module load_store_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter bit MISALIGN_SPLIT = 1'b1
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      req_valid,
  output logic                                      req_ready,
  input  logic                                      req_we,
  input  logic [2:0]                                req_func3,
  input  logic [ADDR_WIDTH-1:0]                     req_addr,
  input  logic [DATA_WIDTH-1:0]                     req_wdata,
  output logic                                      rsp_valid,
  output logic [DATA_WIDTH-1:0]                     rsp_rdata,
  output logic                                      rsp_fault,
  output logic                                      mem_en,
  output logic [DATA_WIDTH/8-1:0]                   mem_we,
  output logic [ADDR_WIDTH-$clog2(DATA_WIDTH/8)-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]                     mem_wdata,
  input  logic [DATA_WIDTH-1:0]                     mem_rdata
);
  localparam int NB  = DATA_WIDTH / 8;
  localparam int OFS = $clog2(NB);
  localparam int WA  = ADDR_WIDTH - OFS;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE0, S_ISSUE1, S_WAIT, S_RESP} state_t;

  state_t                  state, state_next;
  logic                    we_q, fault_q, fault_next;
  logic [2:0]              func3_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q, word0_q, word1_q;

  function automatic logic func3_legal(input logic we, input logic [2:0] f3);
    case (f3)
      3'b000, 3'b001, 3'b010: return 1'b1;
      3'b011:                 return DATA_WIDTH == 64;
      3'b100, 3'b101:         return !we;
      3'b110:                 return !we && DATA_WIDTH == 64;
      default:                return 1'b0;
    endcase
  endfunction

  function automatic logic crosses(input logic [OFS-1:0] off, input logic [1:0] szc);
    return (int'(off) + (1 << szc)) > NB;
  endfunction

  logic [OFS-1:0]           off_q;
  int                       sz_q;
  logic                     split_q;
  logic [WA-1:0]            word0_addr;
  logic [2*NB-1:0]          mask2;
  logic [2*DATA_WIDTH-1:0]  data2, shifted2;
  logic [DATA_WIDTH-1:0]    wsz, shifted, load_ext;
  logic                     sign_bit;

  assign off_q      = addr_q[OFS-1:0];
  assign sz_q       = 1 << func3_q[1:0];
  assign split_q    = crosses(off_q, func3_q[1:0]);
  assign word0_addr = addr_q[ADDR_WIDTH-1:OFS];

  // Store lanes span two words so the second beat is just the upper half.
  always_comb begin
    wsz = '0;
    for (int i = 0; i < NB; i++)
      wsz[8*i +: 8] = (i < sz_q) ? wdata_q[8*i +: 8] : 8'h00;
    data2 = {{DATA_WIDTH{1'b0}}, wsz} << {off_q, 3'b000};
    mask2 = '0;
    for (int i = 0; i < 2*NB; i++)
      mask2[i] = (i >= int'(off_q)) && (i < int'(off_q) + sz_q);
  end

  always_comb begin
    shifted2 = {word1_q, word0_q} >> {off_q, 3'b000};
    shifted  = shifted2[DATA_WIDTH-1:0];
    case (func3_q[1:0])
      2'd0:    sign_bit = shifted[7];
      2'd1:    sign_bit = shifted[15];
      2'd2:    sign_bit = shifted[31];
      default: sign_bit = shifted[DATA_WIDTH-1];
    endcase
    sign_bit = sign_bit & !func3_q[2];
    load_ext = '0;
    for (int i = 0; i < NB; i++)
      load_ext[8*i +: 8] = (i < sz_q) ? shifted[8*i +: 8] : {8{sign_bit}};
  end

  always_comb begin
    state_next = state;
    fault_next = 1'b0;
    req_ready  = 1'b0;
    mem_en     = 1'b0;
    mem_we     = '0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state)
      S_IDLE: begin
        req_ready  = 1'b1;
        fault_next = !func3_legal(req_we, req_func3) ||
                     (!MISALIGN_SPLIT && crosses(req_addr[OFS-1:0], req_func3[1:0]));
        if (req_valid) state_next = fault_next ? S_RESP : S_ISSUE0;
      end
      S_ISSUE0: begin
        mem_en     = 1'b1;
        mem_addr   = word0_addr;
        mem_we     = we_q ? mask2[NB-1:0] : '0;
        mem_wdata  = we_q ? data2[DATA_WIDTH-1:0] : '0;
        state_next = split_q ? S_ISSUE1 : (we_q ? S_RESP : S_WAIT);
      end
      S_ISSUE1: begin
        mem_en     = 1'b1;
        mem_addr   = word0_addr + WA'(1);
        mem_we     = we_q ? mask2[2*NB-1:NB] : '0;
        mem_wdata  = we_q ? data2[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
        state_next = we_q ? S_RESP : S_WAIT;
      end
      S_WAIT:  state_next = S_RESP;
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign rsp_valid = (state == S_RESP);
  assign rsp_fault = (state == S_RESP) && fault_q;
  assign rsp_rdata = (state == S_RESP && !we_q && !fault_q) ? load_ext : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      we_q    <= 1'b0;
      fault_q <= 1'b0;
      func3_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      word0_q <= '0;
      word1_q <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: if (req_valid) begin
          we_q    <= req_we;
          func3_q <= req_func3;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          fault_q <= fault_next;
          word0_q <= '0;
          word1_q <= '0;
        end
        S_ISSUE1: if (!we_q) word0_q <= mem_rdata;
        S_WAIT: begin
          if (split_q) word1_q <= mem_rdata;
          else         word0_q <= mem_rdata;
        end
        default: ;
      endcase
    end
  end
endmodule
